// File: rtl/rename_unit_pkg.sv
// Shared parameters, tag type and helpers for the rename stage.
// Imported by the free list and the rename unit top.
package rename_unit_pkg;

   localparam int N_ARCH = 32;
   localparam int N_PHYS = 64;
   localparam int PREG_W = $clog2(N_PHYS);
   localparam int AREG_W = $clog2(N_ARCH);
   localparam int FL_N   = N_PHYS - N_ARCH;
   localparam int FL_W   = $clog2(FL_N);

   typedef struct packed {
      logic [PREG_W-1:0] idx;
      logic              ready;
   } tag_t;

   function automatic tag_t mk_tag(
      input logic [PREG_W-1:0] idx,
      input logic              rdy
   );
      tag_t t;
      t.idx   = idx;
      t.ready = rdy;
      return t;
   endfunction

   // A tag being broadcast this cycle reads as ready.
   function automatic tag_t bypass(
      input tag_t              m,
      input logic              cv,
      input logic [PREG_W-1:0] ct
   );
      tag_t t;
      t = m;
      if (cv && (ct == m.idx)) t.ready = 1'b1;
      return t;
   endfunction

endpackage

// File: rtl/rename_unit_free_list.sv
// Circular free list of physical tags with a committed read pointer
// so a squash can rewind speculative pops.
module rename_unit_free_list
   import rename_unit_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              pop_i,
   input  logic              push_i,
   input  logic [PREG_W-1:0] push_tag_i,
   input  logic              restore_i,
   output logic [PREG_W-1:0] head_tag_o,
   output logic [PREG_W:0]   count_o
);

   logic [PREG_W-1:0] mem_q [FL_N];
   logic [FL_W-1:0]   head_q, head_d;
   logic [FL_W-1:0]   rhead_q, rhead_d;
   logic [FL_W-1:0]   tail_q, tail_d;
   logic [PREG_W:0]   count_q, count_d;

   // Next pointers; restore rewinds head to the committed point.
   always_comb begin
      rhead_d = rhead_q + FL_W'(push_i);
      tail_d  = tail_q + FL_W'(push_i);
      head_d  = head_q + FL_W'(pop_i);
      count_d = count_q + (PREG_W+1)'(push_i)
                        - (PREG_W+1)'(pop_i);
      if (restore_i) begin
         head_d  = rhead_d;
         count_d = (PREG_W+1)'(FL_N);
      end
   end

   // Storage and pointer registers; reset loads N_ARCH..N_PHYS-1.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < FL_N; i++)
            mem_q[i] <= PREG_W'(N_ARCH + i);
         head_q  <= '0;
         rhead_q <= '0;
         tail_q  <= '0;
         count_q <= (PREG_W+1)'(FL_N);
      end else begin
         if (push_i) mem_q[tail_q] <= push_tag_i;
         head_q  <= head_d;
         rhead_q <= rhead_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Retires can never return more tags than were handed out.
   always_ff @(posedge clock) begin
      if (!reset) assert (count_d <= (PREG_W+1)'(FL_N));
   end

   assign head_tag_o = mem_q[head_q];
   assign count_o    = count_q;

endmodule

// File: rtl/rename_unit.sv
// R10K-style rename stage: speculative and architectural map tables,
// source lookup with CDB ready bypass, and free-list allocation.
module rename_unit
   import rename_unit_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              dispatch_valid,
   input  logic              dispatch_has_dest,
   input  logic [4:0]        dispatch_rs1,
   input  logic [4:0]        dispatch_rs2,
   input  logic [4:0]        dispatch_rd,
   output logic [PREG_W:0]   T,
   output logic [PREG_W:0]   T1,
   output logic [PREG_W:0]   T2,
   output logic [PREG_W:0]   T_old,
   output logic              rename_stall,
   input  logic              cdb_valid,
   input  logic [PREG_W-1:0] cdb_tag,
   input  logic              retire_valid,
   input  logic [4:0]        retire_rd,
   input  logic [PREG_W-1:0] retire_T,
   input  logic [PREG_W-1:0] retire_T_old,
   input  logic              squash,
   output logic [PREG_W:0]   free_count
);

   tag_t              map_q  [N_ARCH];
   tag_t              arch_q [N_ARCH];
   tag_t              arch_d [N_ARCH];
   logic              alloc;
   logic [PREG_W-1:0] head_tag;
   logic [PREG_W:0]   count;

   rename_unit_free_list u_fl (
      .clock      (clock),
      .reset      (reset),
      .pop_i      (alloc),
      .push_i     (retire_valid),
      .push_tag_i (retire_T_old),
      .restore_i  (squash),
      .head_tag_o (head_tag),
      .count_o    (count)
   );

   assign free_count   = count;
   assign rename_stall = (count == '0);
   assign alloc = dispatch_valid && dispatch_has_dest &&
                  (dispatch_rd != '0) && !rename_stall && !squash;

   // Lookup reads the pre-edge map, so rs == rd sees the old mapping.
   always_comb begin
      T1 = mk_tag('0, 1'b1);
      T2 = mk_tag('0, 1'b1);
      if (dispatch_rs1 != '0)
         T1 = bypass(map_q[dispatch_rs1], cdb_valid, cdb_tag);
      if (dispatch_rs2 != '0)
         T2 = bypass(map_q[dispatch_rs2], cdb_valid, cdb_tag);
      T_old = bypass(map_q[dispatch_rd], cdb_valid, cdb_tag);
      T = alloc ? mk_tag(head_tag, 1'b0) : mk_tag('0, 1'b1);
   end

   // Architectural image including this cycle's retire.
   always_comb begin
      for (int i = 0; i < N_ARCH; i++) arch_d[i] = arch_q[i];
      if (retire_valid) arch_d[retire_rd] = mk_tag(retire_T, 1'b1);
   end

   // Architectural map register.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < N_ARCH; i++)
            arch_q[i] <= mk_tag(PREG_W'(i), 1'b1);
      end else begin
         for (int i = 0; i < N_ARCH; i++)
            arch_q[i] <= arch_d[i];
      end
   end

   // Speculative map: squash restore, else CDB wakeup then allocation.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < N_ARCH; i++)
            map_q[i] <= mk_tag(PREG_W'(i), 1'b1);
      end else if (squash) begin
         for (int i = 0; i < N_ARCH; i++)
            map_q[i] <= arch_d[i];
      end else begin
         for (int i = 0; i < N_ARCH; i++)
            if (cdb_valid && (map_q[i].idx == cdb_tag))
               map_q[i].ready <= 1'b1;
         if (alloc)
            map_q[dispatch_rd] <= mk_tag(head_tag, 1'b0);
      end
   end

endmodule

// File: tb/tb_rename_unit.sv
// Self-checking bench for rename_unit: directed scenarios with literal
// expectations followed by randomized traffic against a queue-based model.
module tb_rename_unit;

   logic       clock = 1'b0;
   logic       reset;
   logic       dv, dhd;
   logic [4:0] rs1, rs2, rd;
   logic [6:0] T, T1, T2, T_old;
   logic       stall;
   logic       cv;
   logic [5:0] ctag;
   logic       rv;
   logic [4:0] rrd;
   logic [5:0] rT, rTold;
   logic       sq;
   logic [6:0] fcount;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clock = ~clock;

   rename_unit dut (
      .clock             (clock),
      .reset             (reset),
      .dispatch_valid    (dv),
      .dispatch_has_dest (dhd),
      .dispatch_rs1      (rs1),
      .dispatch_rs2      (rs2),
      .dispatch_rd       (rd),
      .T                 (T),
      .T1                (T1),
      .T2                (T2),
      .T_old             (T_old),
      .rename_stall      (stall),
      .cdb_valid         (cv),
      .cdb_tag           (ctag),
      .retire_valid      (rv),
      .retire_rd         (rrd),
      .retire_T          (rT),
      .retire_T_old      (rTold),
      .squash            (sq),
      .free_count        (fcount)
   );

   // Model: map as plain arrays, readiness per physical register,
   // free list as FIFO of non-architectural tags, nalloc speculative pops.
   typedef struct {
      int rd;
      int t;
      int told;
   } rob_t;

   int   midx [32];
   int   amap [32];
   bit   prdy [64];
   int   fl   [$];
   int   nalloc;
   rob_t rob  [$];

   function automatic logic [6:0] tag7(input int idx, input bit r);
      return {6'(idx), r};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] look(input int r);
      int i;
      if (r == 0) return tag7(0, 1'b1);
      i = midx[r];
      return tag7(i, prdy[i] || (cv && (int'(ctag) == i)));
   endfunction

   function automatic bit m_alloc();
      return dv && dhd && (rd != 5'd0) && (nalloc < 32) && !sq;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         midx[i] = i;
         amap[i] = i;
      end
      for (int i = 0; i < 64; i++) prdy[i] = (i < 32);
      fl.delete();
      for (int i = 32; i < 64; i++) fl.push_back(i);
      nalloc = 0;
      rob.delete();
   endtask

   task automatic model_check();
      bit a;
      a = m_alloc();
      chk("T", T, a ? tag7(fl[nalloc], 1'b0) : tag7(0, 1'b1));
      chk("T1", T1, look(int'(rs1)));
      chk("T2", T2, look(int'(rs2)));
      if (a) chk("T_old", T_old, look(int'(rd)));
      chk("stall", stall, nalloc == 32);
      chk("free_count", fcount, 32 - nalloc);
   endtask

   task automatic model_update();
      bit a;
      int at;
      rob_t e;
      if (reset) begin
         model_reset();
         return;
      end
      a  = m_alloc();
      at = a ? fl[nalloc] : 0;
      if (rv) begin
         amap[rrd] = int'(rT);
         e = rob.pop_front();
         void'(fl.pop_front());
         fl.push_back(int'(rTold));
         nalloc--;
      end
      if (sq) begin
         for (int i = 0; i < 32; i++) begin
            midx[i] = amap[i];
            prdy[amap[i]] = 1'b1;
         end
         nalloc = 0;
         rob.delete();
      end else begin
         if (cv) prdy[ctag] = 1'b1;
         if (a) begin
            e.rd = int'(rd);
            e.t = at;
            e.told = midx[rd];
            rob.push_back(e);
            midx[rd] = at;
            prdy[at] = 1'b0;
            nalloc++;
         end
      end
   endtask

   task automatic idle();
      reset = 1'b0;
      dv = 1'b0; dhd = 1'b0;
      rs1 = '0; rs2 = '0; rd = '0;
      cv = 1'b0; ctag = '0;
      rv = 1'b0; rrd = '0; rT = '0; rTold = '0;
      sq = 1'b0;
   endtask

   task automatic set_retire();
      if (rob.size() > 0) begin
         rv    = 1'b1;
         rrd   = 5'(rob[0].rd);
         rT    = 6'(rob[0].t);
         rTold = 6'(rob[0].told);
      end
   endtask

   task automatic pre();
      #1;
      model_check();
   endtask

   task automatic post();
      @(posedge clock);
      model_update();
      @(negedge clock);
   endtask

   task automatic cyc();
      pre();
      post();
   endtask

   task automatic alloc_rd(input int r);
      idle();
      dv = 1'b1; dhd = 1'b1; rd = 5'(r);
      cyc();
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      cyc();
      idle();
   endtask

   initial begin
      int ph;
      idle();
      reset = 1'b1;
      @(posedge clock);
      model_reset();
      @(negedge clock);
      idle();

      // Reset image
      pre();
      chk("rst_count", fcount, 32);
      chk("rst_stall", stall, 0);
      post();

      // First allocation, rs == rd returns old mapping
      idle();
      dv = 1'b1; dhd = 1'b1; rd = 5'd1; rs1 = 5'd1; rs2 = 5'd0;
      pre();
      chk("t1_T", T, tag7(32, 0));
      chk("t1_Told", T_old, tag7(1, 1));
      chk("t1_T1", T1, tag7(1, 1));
      chk("t1_T2", T2, tag7(0, 1));
      post();
      idle(); rs1 = 5'd1;
      pre();
      chk("t1_map1", T1, tag7(32, 0));
      post();

      // CDB bypass then persistent wakeup
      idle(); rs1 = 5'd1; cv = 1'b1; ctag = 6'd32;
      pre();
      chk("t2_byp", T1, tag7(32, 1));
      post();
      idle(); rs1 = 5'd1;
      pre();
      chk("t2_map1", T1, tag7(32, 1));
      post();

      // Exhaust free list, then one retire refills it
      do_reset();
      for (int i = 0; i < 32; i++) alloc_rd(1);
      idle(); dv = 1'b1; dhd = 1'b1; rd = 5'd2;
      pre();
      chk("t3_count0", fcount, 0);
      chk("t3_stall", stall, 1);
      chk("t3_noalloc", T, tag7(0, 1));
      post();
      idle(); set_retire();
      cyc();
      idle(); dv = 1'b1; dhd = 1'b1; rd = 5'd5;
      pre();
      chk("t3_count1", fcount, 1);
      chk("t3_T", T, tag7(1, 0));
      post();

      // Retire then squash restores map and head
      do_reset();
      alloc_rd(2);
      alloc_rd(3);
      idle(); set_retire();
      cyc();
      idle(); sq = 1'b1;
      cyc();
      idle(); rs1 = 5'd2; rs2 = 5'd3;
      dv = 1'b1; dhd = 1'b1; rd = 5'd4;
      pre();
      chk("t4_map2", T1, tag7(32, 1));
      chk("t4_map3", T2, tag7(3, 1));
      chk("t4_T", T, tag7(33, 0));
      chk("t4_count", fcount, 32);
      post();

      // rd == 0 does not allocate; retire + allocate holds count
      idle(); dv = 1'b1; dhd = 1'b1; rd = 5'd0;
      pre();
      chk("t5_T", T, tag7(0, 1));
      chk("t5_cnt_a", fcount, 31);
      post();
      idle();
      pre();
      chk("t5_cnt_b", fcount, 31);
      post();
      idle(); set_retire();
      dv = 1'b1; dhd = 1'b1; rd = 5'd6;
      cyc();
      idle();
      pre();
      chk("t5_cnt_c", fcount, 31);
      post();

      // Reset mid-operation, with squash/retire ignored
      do_reset();
      for (int i = 0; i < 10; i++) alloc_rd(i + 1);
      idle(); reset = 1'b1; sq = 1'b1; set_retire();
      cyc();
      idle(); rs1 = 5'd3;
      dv = 1'b1; dhd = 1'b1; rd = 5'd7;
      pre();
      chk("t6_T", T, tag7(32, 0));
      chk("t6_map3", T1, tag7(3, 1));
      chk("t6_count", fcount, 32);
      post();

      // Randomized traffic in phases of light and heavy retirement
      for (int i = 0; i < 3000; i++) begin
         ph = (i / 300) % 2;
         idle();
         reset = ($urandom_range(0, 999) < 5);
         dv  = ($urandom_range(0, 9) < 7);
         dhd = ($urandom_range(0, 9) < 8);
         rd  = $urandom_range(0, 1) ? 5'($urandom_range(0, 7))
                                    : 5'($urandom_range(0, 31));
         rs1 = ($urandom_range(0, 3) == 0) ? rd
                                           : 5'($urandom_range(0, 31));
         rs2 = 5'($urandom_range(0, 31));
         if (ph == 1) sq = ($urandom_range(0, 99) < 3);
         if ($urandom_range(0, 9) < (ph == 1 ? 6 : 1)) set_retire();
         if ($urandom_range(0, 1) == 1) begin
            cv = 1'b1;
            if (rob.size() > 0 && $urandom_range(0, 1) == 1)
               ctag = 6'(rob[$urandom_range(0, rob.size() - 1)].t);
            else
               ctag = 6'($urandom_range(0, 63));
            if (m_alloc() && int'(ctag) == fl[nalloc]) cv = 1'b0;
         end
         cyc();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_fail);
      $finish;
   end

endmodule
